// File: rtl/router_pkg.sv
// Shared constants and types for the router output-port arbiter slice.
package router_pkg;

    localparam int ROUTER_NUM_IN  = 4;
    localparam int ROUTER_FLIT_W  = 32;
    localparam int ROUTER_CREDITS = 4;
    localparam int CREDIT_W       = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [ROUTER_FLIT_W-1:0] data;
        logic                     head;
        logic                     tail;
    } flit_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority encoder: returns the first requester
// found when scanning from ptr upward, wrapping modulo N.
module rr_picker #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    int pos;

    // Scan offsets from farthest to nearest so the nearest match is written last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            pos = int'(ptr) + k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (req[pos]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/router_port_arbiter.sv
// Output-port controller: round-robin packet arbitration with wormhole
// locking, downstream credit gating and a registered output flit stage.
module router_port_arbiter
    import router_pkg::*;
#(
    parameter int NUM_IN  = ROUTER_NUM_IN,
    parameter int FLIT_W  = ROUTER_FLIT_W,
    parameter int CREDITS = ROUTER_CREDITS,
    parameter int IDX_W   = $clog2(NUM_IN)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN-1:0]        in_valid,
    input  logic [NUM_IN*FLIT_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_head,
    input  logic [NUM_IN-1:0]        in_tail,
    output logic [NUM_IN-1:0]        in_ready,
    output logic                     out_valid,
    output logic [FLIT_W-1:0]        out_data,
    output logic                     out_head,
    output logic                     out_tail,
    input  logic                     credit_return,
    output logic [IDX_W-1:0]         grant_id,
    output logic                     busy,
    output logic                     credit_err
);

    localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDITS);
    localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_IN - 1);

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    owner_q, owner_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [CREDIT_W-1:0] credits_q, credits_d;
    logic                credit_err_q, credit_err_d;
    logic                out_valid_q, out_valid_d;
    logic [FLIT_W-1:0]   out_data_q, out_data_d;
    logic                out_head_q, out_head_d;
    logic                out_tail_q, out_tail_d;

    logic                xfer;
    logic [FLIT_W-1:0]   sel_data;
    logic                sel_head;
    logic                sel_tail;
    logic                pick_found;
    logic [IDX_W-1:0]    pick_idx;

    rr_picker #(
        .N     (NUM_IN),
        .IDX_W (IDX_W)
    ) u_picker (
        .req   (in_valid & in_head),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign sel_data = in_data[owner_q*FLIT_W +: FLIT_W];
    assign sel_head = in_head[owner_q];
    assign sel_tail = in_tail[owner_q];
    assign xfer     = |(in_valid & in_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= '0;
            credits_q    <= CREDIT_MAX;
            credit_err_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_head_q   <= 1'b0;
            out_tail_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            credits_q    <= credits_d;
            credit_err_q <= credit_err_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_head_q   <= out_head_d;
            out_tail_q   <= out_tail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        credits_d    = credits_q;
        credit_err_d = credit_err_q;
        out_valid_d  = xfer;
        out_data_d   = out_data_q;
        out_head_d   = out_head_q;
        out_tail_d   = out_tail_q;

        if (xfer) begin
            out_data_d = sel_data;
            out_head_d = sel_head;
            out_tail_d = sel_tail;
        end

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d = ARB_LOCK;
                    owner_d = pick_idx;
                end
            end
            ARB_LOCK: begin
                if (xfer && sel_tail) begin
                    state_d  = ARB_IDLE;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + IDX_W'(1);
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // A transfer can only happen with credits available, so no underflow.
        case ({xfer, credit_return})
            2'b10: credits_d = credits_q - CREDIT_W'(1);
            2'b01: begin
                if (credits_q == CREDIT_MAX) begin
                    credit_err_d = 1'b1;
                end else begin
                    credits_d = credits_q + CREDIT_W'(1);
                end
            end
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            in_ready[i] = (state_q == ARB_LOCK) && (owner_q == IDX_W'(i)) &&
                          (credits_q != '0);
        end
        busy       = (state_q == ARB_LOCK);
        grant_id   = owner_q;
        out_valid  = out_valid_q;
        out_data   = out_data_q;
        out_head   = out_head_q;
        out_tail   = out_tail_q;
        credit_err = credit_err_q;
    end

endmodule

// File: doc/router_port_arbiter.md
Name: router_port_arbiter

Overview:
- Sequential output-port controller for a router slice.
- Shares one output link between NUM_IN input ports.
- Uses round-robin arbitration on packet heads and holds the grant for the whole packet (wormhole locking).
- Gates forwarding with a downstream credit counter; sits between the input buffers and the output-link register.

Parameters:
- NUM_IN, 4, number of requesting input ports (2..8)
- FLIT_W, 32, flit payload width in bits
- CREDITS, 4, downstream buffer depth in flits (1..15)
- IDX_W, $clog2(NUM_IN), width of a port index

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  NUM_IN  per-port flit valid
- in_data  in  NUM_IN*FLIT_W  per-port flit payload; port i occupies bits [i*FLIT_W +: FLIT_W]
- in_head  in  NUM_IN  flit is the head of a packet
- in_tail  in  NUM_IN  flit is the tail of a packet (head and tail together = single-flit packet)
- in_ready  out  NUM_IN  per-port accept
- out_valid  out  1  registered output flit valid
- out_data  out  FLIT_W  registered output payload
- out_head  out  1  registered head flag
- out_tail  out  1  registered tail flag
- credit_return  in  1  downstream freed one buffer slot this cycle
- grant_id  out  IDX_W  current owner index; valid while busy
- busy  out  1  a packet is locked to the output
- credit_err  out  1  sticky: a credit_return arrived while the counter was already full

Behaviour:
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_data=0, out_head=0, out_tail=0, grant_id=0, busy=0, credits=CREDITS, rr_ptr=0, credit_err=0.
- A transfer on port i occurs when in_valid[i] & in_ready[i].
- in_ready[i] = (state==LOCK) & (owner==i) & (credits!=0). It is combinational from registers only and never depends on in_valid.
- State IDLE:
  - Candidates are ports with in_valid & in_head.
  - Winner is the first candidate found scanning rr_ptr, rr_ptr+1, ... modulo NUM_IN.
  - If any candidate exists: next state LOCK, owner=winner, busy=1, grant_id=winner.
  - No flit is accepted in IDLE, so arbitration costs 1 cycle.
  - Valid non-head flits are ignored, not errors.
- State LOCK:
  - Only the owner can transfer.
  - Each transfer registers the flit onto out_* in the next cycle (1-cycle latency); out_valid=1 for exactly one cycle per transfer.
  - A transfer with in_tail set returns state to IDLE, sets rr_ptr=(owner+1) mod NUM_IN and clears busy in the next cycle.
  - A single-flit packet therefore occupies 2 cycles (grant, transfer).
  - A head flag on a non-first flit inside LOCK is forwarded unchanged; no re-arbitration.
- Credits:
  - 4-bit counter.
  - Transfer with no credit_return: decrement.
  - credit_return with no transfer: increment, saturating at CREDITS.
  - Both in the same cycle: unchanged.
  - credit_return while credits==CREDITS and no transfer: counter stays, credit_err=1 until reset.
  - credits==0: in_ready deasserts; the owner stalls and the lock is held.
- Owner drops in_valid mid-packet: the lock is held indefinitely with no timeout.
- Reset mid-packet: the partial packet is abandoned and all registers take their reset values in the same cycle; credits return to CREDITS.
- No combinational path from any input to out_*, grant_id or busy.

Decomposition:
- Package router_pkg holds:
  - constants ROUTER_NUM_IN=4, ROUTER_FLIT_W=32, ROUTER_CREDITS=4
  - enum arb_state_t {ARB_IDLE, ARB_LOCK}
  - struct flit_t {data, head, tail}
- One sub-module, rr_picker: a purely combinational round-robin priority encoder (req vector, ptr -> found, idx).
- Everything else (FSM, credit counter, output register) lives in router_port_arbiter.

Test Plan:
- Reset, then only port 2 sends a 3-flit packet (H, -, T) -> grant_id=2 one cycle after the head; out_valid on 3 consecutive cycles carrying data D0, D1, D2; out_tail only on the third; busy drops afterwards; rr_ptr=3.
- Ports 0 and 1 each present a single-flit packet continuously, rr_ptr=0 -> grants alternate 0, 1, 0, 1; each packet takes 2 cycles, so out_valid toggles 1/0.
- CREDITS=4, port 0 sends a 6-flit packet with no credit_return -> 4 flits forwarded, then in_ready[0]=0 and busy stays 1. Two credit_return pulses -> remaining 2 flits forwarded, credits end at 0.
- Transfer and credit_return in the same cycle with credits=2 -> credits remains 2. credit_return at credits=4 with no transfer -> credit_err=1, credits stays 4.
- rst asserted in the middle of a 4-flit packet -> next cycle busy=0, in_ready=0, out_valid=0, credits=4. A new head on port 3 is then granted normally.
- Port 1 holds a valid non-head flit in IDLE -> in_ready[1] stays 0 and no grant is issued for 10 cycles.
